// File: rtl/spart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spart_pkg                                                    |
// | Description : Shared SPART types and constants (transmit and receive).     |
// |               Macro SPART_TX_PARITY_EN adds the PARITY state and makes     |
// |               frames 11 bits long.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spart_pkg;

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd4
  } tx_state_t;

  localparam int FRAME_BITS = 10;
`endif

  // Register select value of the transmit buffer on the processor bus.
  localparam logic [1:0] IOADDR_TXBUF = 2'b00;

endpackage
`default_nettype wire

// File: rtl/spart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spart_bit_timer                                              |
// | Description : Counts oversampling ticks and flags the tick that ends a     |
// |               serial bit. Clear may preload half a bit (receiver use).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spart_bit_timer #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic preload,
  input  logic enable,
  output logic bit_done
);

  localparam int            c_cw        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0] c_last_tick = c_cw'(TICKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_half_tick = c_cw'(TICKS_PER_BIT / 2);

  logic [c_cw-1:0] r_count;

  // The bit ends on the tick that sees the last count value.
  assign bit_done = enable && (r_count == c_last_tick);

  // Tick counter: clear has priority, otherwise advance and wrap on each tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= preload ? c_half_tick : '0;
    end else if (enable) begin
      r_count <= bit_done ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spart_tx                                                     |
// | Description : SPART transmitter. One-byte holding register feeding an     |
// |               8N1 LSB-first serializer paced by the enable tick.           |
// |               Define SPART_TX_PARITY_EN to add an even-parity bit.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spart_tx
  import spart_pkg::*;
#(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus,
  input  logic       enable,
  output logic       txd,
  output logic       tbr
);

  tx_state_t  r_state, w_state_nxt;
  logic [7:0] r_hold,  w_hold_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_idx,   w_idx_nxt;
  logic       r_txd,   w_txd_nxt;
  logic       r_tbr,   w_tbr_nxt;
`ifdef SPART_TX_PARITY_EN
  logic       r_par,   w_par_nxt;
`endif

  logic w_wr;
  logic w_load;
  logic w_clr;
  logic w_bit_done;

  assign txd = r_txd;
  assign tbr = r_tbr;

  // Bus write strobe aimed at the transmit buffer.
  assign w_wr = iocs && !iorw && (ioaddr == IOADDR_TXBUF);

  // Holding byte moves to the shifter when the line is idle or a stop bit ends.
  assign w_load = !r_tbr &&
                  ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_done));

  spart_bit_timer #(
    .TICKS_PER_BIT (TICKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .preload  (1'b0),
    .enable   (enable),
    .bit_done (w_bit_done)
  );

  // Next-state and next-output logic for the serializer and holding register.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_txd_nxt   = r_txd;
    w_tbr_nxt   = r_tbr;
    w_clr       = 1'b0;
`ifdef SPART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      TX_IDLE: begin
        w_txd_nxt = 1'b1;
      end
      TX_START: begin
        if (w_bit_done) begin
          w_state_nxt = TX_DATA;
          w_idx_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
        end
      end
      TX_DATA: begin
        if (w_bit_done) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
            w_state_nxt = TX_PARITY;
            w_txd_nxt   = r_par;
`else
            w_state_nxt = TX_STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_txd_nxt   = r_shift[1];
          end
        end
      end
`ifdef SPART_TX_PARITY_EN
      TX_PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = TX_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (w_bit_done) begin
          w_state_nxt = TX_IDLE;
          w_txd_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase

    // Transfer overrides the state update; it also covers the back-to-back case.
    if (w_load) begin
      w_state_nxt = TX_START;
      w_shift_nxt = r_hold;
      w_txd_nxt   = 1'b0;
      w_tbr_nxt   = 1'b1;
      w_clr       = 1'b1;
`ifdef SPART_TX_PARITY_EN
      w_par_nxt   = ^r_hold;
`endif
    end

    // Writes land only in an empty holding register; a transfer needs tbr low,
    // so the two never collide.
    if (w_wr && r_tbr) begin
      w_hold_nxt = databus;
      w_tbr_nxt  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= TX_IDLE;
      r_hold  <= 8'h00;
      r_shift <= 8'h00;
      r_idx   <= 3'd0;
      r_txd   <= 1'b1;
      r_tbr   <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_txd   <= w_txd_nxt;
      r_tbr   <= w_tbr_nxt;
`ifdef SPART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/spart_tx.md
# spart_tx

Transmit stage of the SPART, directly downstream of the baud-rate generator. It accepts a byte from the processor bus, serializes it as an 8N1 asynchronous frame (LSB first) on `txd`, and paces every bit with the `enable` oversampling tick the baud-rate generator produces. A one-byte holding register in front of the shift register supports back-to-back frames with no idle gap.

## Interface
- `TICKS_PER_BIT`, default 16: number of `enable` pulses per serial bit.

- `clk` input 1: single clock; all state in this domain.
- `rst` input 1: asynchronous, active-low reset.
- `iocs` input 1: chip select.
- `iorw` input 1: 0 = write, 1 = read. This block acts on writes only.
- `ioaddr` input 2: register select. `2'b00` is the transmit buffer.
- `databus` input 8: write data. This block never drives the bus.
- `enable` input 1: one-cycle oversampling tick from the baud-rate generator.
- `txd` output 1: serial line, idle high.
- `tbr` output 1: transmit buffer ready (holding register empty).

## Operation
- Write strobe: `iocs && !iorw && ioaddr == 2'b00`.
  - If `tbr = 1`: the byte is captured into the holding register and `tbr` falls on the next edge.
  - If `tbr = 0`: the write is ignored. There is no overwrite and no error flag.
- States: IDLE, START, DATA, STOP, plus PARITY when enabled (see Configuration).
- IDLE, holding register full:
  - On the next edge, the holding byte moves to the shift register.
  - `tbr` rises, the state goes to START, `txd` goes to 0, and the tick counter clears.
- Tick counter:
  - Range 0..`TICKS_PER_BIT`-1, width `$clog2(TICKS_PER_BIT)`.
  - Increments only on cycles with `enable = 1`.
  - A bit ends on the `enable` pulse where the count equals `TICKS_PER_BIT`-1; the counter wraps to 0 on that pulse.
- START ends → DATA with bit index 0. `txd` = shift[0].
- DATA: each bit end shifts right and increments the 3-bit index. After index 7 ends → STOP, `txd` = 1.
- STOP ends:
  - Holding register full → START directly (back-to-back transfer on that edge, `tbr` rises).
  - Otherwise → IDLE.
- A write and `enable` in the same cycle are independent; both take effect.
- A write in the same cycle as the holding-to-shift transfer cannot occur, because a transfer requires `tbr = 0`.

## Timing
- Reset values: `txd = 1`, `tbr = 1`, state IDLE, counter 0, holding and shift registers 0.
- Reset is asserted asynchronously. Asserting it mid-frame forces `txd` high immediately and discards both bytes.
- `txd` and `tbr` are registered; there are no combinational paths from inputs.
- Latency:
  - A write while IDLE makes `txd` fall 2 clock edges after the write cycle (capture edge, then transfer edge).
  - Frame length is 10 × `TICKS_PER_BIT` `enable` pulses, or 11 × with parity.
- If `enable` is held high every cycle, a bit lasts exactly `TICKS_PER_BIT` clocks.

## Configuration
- `SPART_TX_PARITY_EN` defined:
  - The PARITY state is inserted between DATA and STOP.
  - `txd` carries the even-parity bit, i.e. the XOR of the 8 data bits.
  - The parity bit is computed when the byte is transferred to the shift register.
- Undefined: the PARITY state, parity register and XOR logic are not compiled in; frames are 8N1.

## Structure
- Shared package `spart_pkg` holds:
  - the `tx_state_t` enum;
  - localparam `IOADDR_TXBUF = 2'b00`;
  - localparam `FRAME_BITS`.
  The receive side uses the same package.
- Sub-module `spart_bit_timer`: the tick counter. Input `enable`, synchronous clear, output `bit_done`, parameter `TICKS_PER_BIT`. The receiver reuses it with a half-bit preload.

## Test plan
- **Reset:** assert `rst` with no writes → `txd = 1` and `tbr = 1` persist for 1000 cycles.
- **Single byte:** `enable` high every cycle, write 0x55 → `txd` = 0,1,0,1,0,1,0,1,0,1, each bit 16 clocks, then stays 1. `tbr` low for exactly 1 cycle.
- **Back-to-back:**
  - Write 0xA3, wait for `tbr`, write 0x0F → two frames with no idle gap.
  - The second start bit begins on the edge that ends the first stop bit.
- **Dropped write:** write 0x11, then 0x22 while `tbr = 0` → one frame only, carrying 0x11.
- **Reset mid-frame:** assert `rst` during DATA bit 3 → `txd = 1` immediately; no frame resumes after release.
- **Parity (with `SPART_TX_PARITY_EN`):** write 0x07 → parity bit 1. Write 0x03 → parity bit 0. Each frame is 176 clocks long.
